// File: rtl/moxie_fde_pipeline_if.sv
// Bus bundle for the Moxie fetch/decode/execute block.
// master: the pipeline (drives fetch address, register read indices and
//         registered execute results; receives instruction data, stall and
//         register-file read data).
// slave : the surrounding core (instruction memory, register file, write stage).
interface moxie_fde_pipeline_if;
  logic [31:0] imem_address_o;
  logic [31:0] imem_data_i;
  logic        stall_i;
  logic [3:0]  riA_o;
  logic [3:0]  riB_o;
  logic [31:0] regA_i;
  logic [31:0] regB_i;
  logic        register_write_enable_o;
  logic [3:0]  register_write_index_o;
  logic [31:0] result_o;
  logic        memory_write_enable_o;
  logic [31:0] memory_write_address_o;

  modport master (
    output imem_address_o, riA_o, riB_o,
           register_write_enable_o, register_write_index_o, result_o,
           memory_write_enable_o, memory_write_address_o,
    input  imem_data_i, stall_i, regA_i, regB_i
  );

  modport slave (
    input  imem_address_o, riA_o, riB_o,
           register_write_enable_o, register_write_index_o, result_o,
           memory_write_enable_o, memory_write_address_o,
    output imem_data_i, stall_i, regA_i, regB_i
  );
endinterface

// File: rtl/moxie_fde_pipeline.sv
// Moxie front pipeline: fetch, decode and execute with internal branch
// feedback. Fetches 16-bit opcodes plus optional 32-bit immediates,
// decodes an integer subset, reads operands from the external register
// file and registers results for the external write stage.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - synchronous active-high reset
//   bus    - master side of moxie_fde_pipeline_if (imem fetch, stall,
//            register-file reads, registered write/store outputs)
module moxie_fde_pipeline #(
  parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  moxie_fde_pipeline_if.master        bus
);

  typedef enum logic {
    FETCH_OPCODE,
    FETCH_OPERAND
  } fetch_state_e;

  typedef enum logic [3:0] {
    OP_NOP, OP_LDI, OP_MOV, OP_ADD, OP_ST, OP_CMP, OP_JMPA,
    OP_AND, OP_SUB, OP_OR, OP_XOR, OP_INC, OP_DEC, OP_BR
  } op_class_e;

  // Fetch FSM and PC
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;

  // Fetch register
  logic [15:0]  f_op_q, f_op_d;
  logic [31:0]  f_imm_q, f_imm_d;
  logic [31:0]  f_pc_q, f_pc_d;
  logic         f_valid_q, f_valid_d;

  // Decode register
  op_class_e    d_opc_q, d_opc_d;
  logic [3:0]   d_ra_q, d_ra_d;
  logic [3:0]   d_rb_q, d_rb_d;
  logic [31:0]  d_imm_q, d_imm_d;
  logic [31:0]  d_pc_q, d_pc_d;
  logic         d_valid_q, d_valid_d;

  // Execute state: flags {gtu, ltu, gt, lt, eq} and output registers
  logic [4:0]   flags_q, flags_d;
  logic         rwe_q, rwe_d;
  logic [3:0]   widx_q, widx_d;
  logic [31:0]  result_q, result_d;
  logic         mwe_q, mwe_d;
  logic [31:0]  maddr_q, maddr_d;

  logic [15:0]  halfword;
  logic         is_long;
  logic         cond_met;
  logic         take_branch;
  logic [31:0]  br_target;

  assign halfword = bus.imem_data_i[31:16];
  assign is_long  = (halfword[15:8] == 8'h01) || (halfword[15:8] == 8'h1a);

  // ---------------- Fetch FSM: state register ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= FETCH_OPCODE;
    else       state_q <= state_d;
  end

  // ---------------- Fetch FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (take_branch) begin
      state_d = FETCH_OPCODE;
    end else if (!bus.stall_i) begin
      unique case (state_q)
        FETCH_OPCODE:  if (is_long) state_d = FETCH_OPERAND;
        FETCH_OPERAND: state_d = FETCH_OPCODE;
        default:       state_d = FETCH_OPCODE;
      endcase
    end
  end

  // ---------------- Fetch FSM: outputs ----------------
  // The PC stays on the opcode address while the immediate is fetched,
  // so a 6-byte instruction advances it in one step.
  always_comb begin
    bus.imem_address_o = (state_q == FETCH_OPERAND) ? pc_q + 32'd2 : pc_q;
    pc_d      = pc_q;
    f_op_d    = f_op_q;
    f_imm_d   = f_imm_q;
    f_pc_d    = f_pc_q;
    f_valid_d = f_valid_q;
    if (take_branch) begin
      pc_d      = br_target;
      f_valid_d = 1'b0;
    end else if (!bus.stall_i) begin
      unique case (state_q)
        FETCH_OPCODE: begin
          f_op_d    = halfword;
          f_pc_d    = pc_q;
          f_valid_d = !is_long;
          if (!is_long) pc_d = pc_q + 32'd2;
        end
        FETCH_OPERAND: begin
          f_imm_d   = bus.imem_data_i;
          f_valid_d = 1'b1;
          pc_d      = pc_q + 32'd6;
        end
        default: f_valid_d = 1'b0;
      endcase
    end
  end

  // ---------------- Decode ----------------
  // For branches rB carries the condition code and the operand the
  // sign-extended halfword offset.
  always_comb begin
    d_opc_d   = d_opc_q;
    d_ra_d    = d_ra_q;
    d_rb_d    = d_rb_q;
    d_imm_d   = d_imm_q;
    d_pc_d    = d_pc_q;
    d_valid_d = d_valid_q;
    if (take_branch) begin
      d_valid_d = 1'b0;
    end else if (!bus.stall_i) begin
      d_valid_d = f_valid_q;
      d_pc_d    = f_pc_q;
      d_opc_d   = OP_NOP;
      if (!f_op_q[15]) begin
        d_ra_d  = f_op_q[7:4];
        d_rb_d  = f_op_q[3:0];
        d_imm_d = f_imm_q;
        case (f_op_q[15:8])
          8'h01:   d_opc_d = OP_LDI;
          8'h02:   d_opc_d = OP_MOV;
          8'h05:   d_opc_d = OP_ADD;
          8'h0b:   d_opc_d = OP_ST;
          8'h0e:   d_opc_d = OP_CMP;
          8'h1a:   d_opc_d = OP_JMPA;
          8'h26:   d_opc_d = OP_AND;
          8'h29:   d_opc_d = OP_SUB;
          8'h2b:   d_opc_d = OP_OR;
          8'h2e:   d_opc_d = OP_XOR;
          default: d_opc_d = OP_NOP;
        endcase
      end else if (!f_op_q[14]) begin
        d_ra_d  = f_op_q[11:8];
        d_rb_d  = f_op_q[3:0];
        d_imm_d = {24'd0, f_op_q[7:0]};
        case (f_op_q[13:12])
          2'b00:   d_opc_d = OP_INC;
          2'b01:   d_opc_d = OP_DEC;
          default: d_opc_d = OP_NOP;
        endcase
      end else begin
        d_ra_d  = f_op_q[7:4];
        d_rb_d  = f_op_q[13:10];
        d_imm_d = {{22{f_op_q[9]}}, f_op_q[9:0]};
        d_opc_d = (f_op_q[13:10] < 4'd6) ? OP_BR : OP_NOP;
      end
    end
  end

  assign bus.riA_o = d_ra_q;
  assign bus.riB_o = d_rb_q;

  // ---------------- Execute: branch resolution ----------------
  always_comb begin
    case (d_rb_q)
      4'd0:    cond_met = flags_q[0];
      4'd1:    cond_met = !flags_q[0];
      4'd2:    cond_met = flags_q[1];
      4'd3:    cond_met = flags_q[2];
      4'd4:    cond_met = flags_q[3];
      4'd5:    cond_met = flags_q[4];
      default: cond_met = 1'b0;
    endcase
    br_target   = (d_opc_q == OP_JMPA) ? d_imm_q
                                       : d_pc_q + 32'd2 + {d_imm_q[30:0], 1'b0};
    take_branch = d_valid_q && !bus.stall_i &&
                  ((d_opc_q == OP_JMPA) || ((d_opc_q == OP_BR) && cond_met));
  end

  // ---------------- Execute: results ----------------
  always_comb begin
    rwe_d    = 1'b0;
    mwe_d    = 1'b0;
    widx_d   = widx_q;
    result_d = result_q;
    maddr_d  = maddr_q;
    flags_d  = flags_q;
    if (d_valid_q && !bus.stall_i) begin
      case (d_opc_q)
        OP_LDI: begin rwe_d = 1'b1; widx_d = d_ra_q; result_d = d_imm_q; end
        OP_MOV: begin rwe_d = 1'b1; widx_d = d_ra_q; result_d = bus.regB_i; end
        OP_ADD: begin rwe_d = 1'b1; widx_d = d_ra_q; result_d = bus.regA_i + bus.regB_i; end
        OP_SUB: begin rwe_d = 1'b1; widx_d = d_ra_q; result_d = bus.regA_i - bus.regB_i; end
        OP_AND: begin rwe_d = 1'b1; widx_d = d_ra_q; result_d = bus.regA_i & bus.regB_i; end
        OP_OR:  begin rwe_d = 1'b1; widx_d = d_ra_q; result_d = bus.regA_i | bus.regB_i; end
        OP_XOR: begin rwe_d = 1'b1; widx_d = d_ra_q; result_d = bus.regA_i ^ bus.regB_i; end
        OP_INC: begin rwe_d = 1'b1; widx_d = d_ra_q; result_d = bus.regA_i + d_imm_q; end
        OP_DEC: begin rwe_d = 1'b1; widx_d = d_ra_q; result_d = bus.regA_i - d_imm_q; end
        OP_ST: begin
          mwe_d    = 1'b1;
          maddr_d  = bus.regA_i;
          result_d = bus.regB_i;
        end
        OP_CMP: begin
          flags_d[0] = (bus.regA_i == bus.regB_i);
          flags_d[1] = ($signed(bus.regA_i) < $signed(bus.regB_i));
          flags_d[2] = ($signed(bus.regA_i) > $signed(bus.regB_i));
          flags_d[3] = (bus.regA_i < bus.regB_i);
          flags_d[4] = (bus.regA_i > bus.regB_i);
        end
        default: ;
      endcase
    end
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q      <= RESET_PC;
      f_op_q    <= '0;
      f_imm_q   <= '0;
      f_pc_q    <= '0;
      f_valid_q <= 1'b0;
      d_opc_q   <= OP_NOP;
      d_ra_q    <= '0;
      d_rb_q    <= '0;
      d_imm_q   <= '0;
      d_pc_q    <= '0;
      d_valid_q <= 1'b0;
      flags_q   <= '0;
      rwe_q     <= 1'b0;
      widx_q    <= '0;
      result_q  <= '0;
      mwe_q     <= 1'b0;
      maddr_q   <= '0;
    end else begin
      pc_q      <= pc_d;
      f_op_q    <= f_op_d;
      f_imm_q   <= f_imm_d;
      f_pc_q    <= f_pc_d;
      f_valid_q <= f_valid_d;
      d_opc_q   <= d_opc_d;
      d_ra_q    <= d_ra_d;
      d_rb_q    <= d_rb_d;
      d_imm_q   <= d_imm_d;
      d_pc_q    <= d_pc_d;
      d_valid_q <= d_valid_d;
      flags_q   <= flags_d;
      rwe_q     <= rwe_d;
      widx_q    <= widx_d;
      result_q  <= result_d;
      mwe_q     <= mwe_d;
      maddr_q   <= maddr_d;
    end
  end

  assign bus.register_write_enable_o = rwe_q;
  assign bus.register_write_index_o  = widx_q;
  assign bus.result_o                = result_q;
  assign bus.memory_write_enable_o   = mwe_q;
  assign bus.memory_write_address_o  = maddr_q;

endmodule

// File: tb/tb_moxie_fde_pipeline.sv
// Directed bench for moxie_fde_pipeline: a fixed program in a byte-array
// instruction memory, a preset register file, and a per-cycle table of
// hand-computed fetch addresses and execute outputs.
module tb_moxie_fde_pipeline;
  localparam int unsigned NCYC = 28;

  logic clk;
  logic rst;
  moxie_fde_pipeline_if bus ();

  moxie_fde_pipeline #(.RESET_PC(32'h0000_1000)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  logic [7:0]  mem [0:511];
  logic [31:0] rf  [0:15];
  logic [8:0]  ma;

  always_comb begin
    ma = bus.imem_address_o[8:0];
    bus.imem_data_i = {mem[ma], mem[ma + 9'd1], mem[ma + 9'd2], mem[ma + 9'd3]};
  end
  always_comb bus.regA_i = rf[bus.riA_o];
  always_comb bus.regB_i = rf[bus.riB_o];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic put16(input int unsigned addr, input logic [15:0] hw);
    mem[addr - 32'h1000]      = hw[15:8];
    mem[addr - 32'h1000 + 1]  = hw[7:0];
  endtask

  logic [31:0] exp_addr [0:NCYC-1];
  logic        exp_rwe  [0:NCYC-1];
  logic [3:0]  exp_idx  [0:NCYC-1];
  logic [31:0] exp_res  [0:NCYC-1];
  logic        exp_mwe  [0:NCYC-1];
  logic [31:0] exp_madr [0:NCYC-1];

  task automatic expw(input int unsigned c, input logic [3:0] idx, input logic [31:0] res);
    exp_rwe[c] = 1'b1;
    exp_idx[c] = idx;
    exp_res[c] = res;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    for (int i = 0; i < 16; i++)  rf[i]  = '0;

    // Program
    put16(32'h1000, 16'h0110);  // ldi.l $r1, 0x12345678
    put16(32'h1002, 16'h1234);
    put16(32'h1004, 16'h5678);
    put16(32'h1006, 16'h0523);  // add.l $r2,$r3
    put16(32'h1008, 16'h2923);  // sub.l $r2,$r3
    put16(32'h100A, 16'h0B12);  // st.l  ($r1),$r2
    put16(32'h100C, 16'h0E12);  // cmp   $r1,$r2
    put16(32'h100E, 16'hC004);  // beq   +4 -> 0x1018
    put16(32'h1010, 16'h0245);  // squashed mov
    put16(32'h1012, 16'h8601);  // squashed inc
    put16(32'h1014, 16'h0245);
    put16(32'h1016, 16'h0245);
    put16(32'h1018, 16'h8610);  // inc $r6, 0x10
    put16(32'h101A, 16'h9703);  // dec $r7, 3
    put16(32'h101C, 16'h2E89);  // xor $r8,$r9
    put16(32'h101E, 16'h2689);  // and $r8,$r9
    put16(32'h1020, 16'h2B89);  // or  $r8,$r9
    put16(32'h1022, 16'h02A9);  // mov $r10,$r9
    put16(32'h1024, 16'h1A00);  // jmpa 0x1040
    put16(32'h1026, 16'h0000);
    put16(32'h1028, 16'h1040);
    put16(32'h102A, 16'h02C9);  // squashed mov
    put16(32'h102C, 16'h02C9);  // squashed mov
    put16(32'h102E, 16'h02C9);
    put16(32'h1040, 16'h02B9);  // mov $r11,$r9

    rf[2] = 32'd5;
    rf[3] = 32'd7;
    rf[6] = 32'h0000_0100;
    rf[7] = 32'd2;
    rf[8] = 32'hF0F0_F0F0;
    rf[9] = 32'hFF00_FF00;

    // Expected per-cycle behaviour (cycle 0 = first cycle after reset release)
    for (int c = 0; c < NCYC; c++) begin
      exp_rwe[c]  = 1'b0;
      exp_idx[c]  = '0;
      exp_res[c]  = '0;
      exp_mwe[c]  = 1'b0;
      exp_madr[c] = '0;
    end
    exp_addr[0]  = 32'h1000; exp_addr[1]  = 32'h1002; exp_addr[2]  = 32'h1006;
    exp_addr[3]  = 32'h1008; exp_addr[4]  = 32'h100A; exp_addr[5]  = 32'h100C;
    exp_addr[6]  = 32'h100E; exp_addr[7]  = 32'h1010; exp_addr[8]  = 32'h1012;
    exp_addr[9]  = 32'h1018; exp_addr[10] = 32'h101A; exp_addr[11] = 32'h101C;
    exp_addr[12] = 32'h101E; exp_addr[13] = 32'h1020; exp_addr[14] = 32'h1022;
    exp_addr[15] = 32'h1024; exp_addr[16] = 32'h1024; exp_addr[17] = 32'h1024;
    exp_addr[18] = 32'h1024; exp_addr[19] = 32'h1026; exp_addr[20] = 32'h102A;
    exp_addr[21] = 32'h102C; exp_addr[22] = 32'h1040; exp_addr[23] = 32'h1042;
    exp_addr[24] = 32'h1044; exp_addr[25] = 32'h1046; exp_addr[26] = 32'h1048;
    exp_addr[27] = 32'h104A;

    expw(4,  4'd1,  32'h1234_5678);
    expw(5,  4'd2,  32'd12);
    expw(6,  4'd2,  32'hFFFF_FFFE);
    expw(12, 4'd6,  32'h0000_0110);
    expw(13, 4'd7,  32'hFFFF_FFFF);
    expw(14, 4'd8,  32'h0FF0_0FF0);
    expw(15, 4'd8,  32'hF000_F000);
    expw(19, 4'd8,  32'hFFF0_FFF0);
    expw(20, 4'd10, 32'hFF00_FF00);
    expw(25, 4'd11, 32'hFF00_FF00);
    exp_mwe[7]  = 1'b1;
    exp_madr[7] = 32'h0000_2000;
    exp_res[7]  = 32'h0000_CAFE;

    // Reset
    rst         = 1'b1;
    bus.stall_i = 1'b0;
    @(posedge clk); #1;
    check("rst1_addr", bus.imem_address_o, 32'h1000);
    check("rst1_rwe",  {31'd0, bus.register_write_enable_o}, 32'd0);
    check("rst1_mwe",  {31'd0, bus.memory_write_enable_o}, 32'd0);
    @(posedge clk); #1;
    check("rst2_addr", bus.imem_address_o, 32'h1000);
    check("rst2_rwe",  {31'd0, bus.register_write_enable_o}, 32'd0);
    check("rst2_mwe",  {31'd0, bus.memory_write_enable_o}, 32'd0);
    check("rst2_res",  bus.result_o, 32'd0);
    rst = 1'b0;

    for (int c = 0; c < NCYC; c++) begin
      bus.stall_i = (c >= 15 && c <= 17);
      if (c == 6) begin
        rf[1] = 32'h0000_2000;
        rf[2] = 32'h0000_CAFE;
      end
      if (c == 7) begin
        rf[1] = 32'h0000_0055;
        rf[2] = 32'h0000_0055;
      end
      check($sformatf("addr@%0d", c), bus.imem_address_o, exp_addr[c]);
      check($sformatf("rwe@%0d", c), {31'd0, bus.register_write_enable_o}, {31'd0, exp_rwe[c]});
      check($sformatf("mwe@%0d", c), {31'd0, bus.memory_write_enable_o}, {31'd0, exp_mwe[c]});
      if (exp_rwe[c]) begin
        check($sformatf("widx@%0d", c), {28'd0, bus.register_write_index_o}, {28'd0, exp_idx[c]});
        check($sformatf("res@%0d", c), bus.result_o, exp_res[c]);
      end
      if (exp_mwe[c]) begin
        check($sformatf("madr@%0d", c), bus.memory_write_address_o, exp_madr[c]);
        check($sformatf("sdat@%0d", c), bus.result_o, exp_res[c]);
      end
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/moxie_fde_pipeline.md
# moxie_fde_pipeline

Front three pipeline stages of the Moxie core: fetch, decode and execute in one block, with branch feedback kept internal. The block fetches 16-bit Moxie opcodes and optional 32-bit immediates from instruction memory, decodes a fixed integer subset, and reads operands from the external register file. Registered results leave the block for the external write stage, which drives register-file and data-memory writes.

## Interface
- RESET_PC, 32'h0000_1000, fetch address after reset.
- clk_i  in  1  single clock; all state changes on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- imem_address_o  out  32  byte address of the halfword being fetched; always even.
- imem_data_i  in  32  asynchronous read of the 4 bytes at imem_address_o, big-endian; [31:16] is the halfword at the address.
- stall_i  in  1  freezes fetch and decode; execute inserts a bubble.
- riA_o, riB_o  out  4 each  register-file read indices, combinational from the decode register.
- regA_i, regB_i  in  32 each  register-file read data for riA_o/riB_o, same cycle.
- register_write_enable_o  out  1  registered; result_o goes to register_write_index_o.
- register_write_index_o  out  4  registered destination register.
- result_o  out  32  registered ALU result, or store data.
- memory_write_enable_o  out  1  registered store strobe.
- memory_write_address_o  out  32  registered store address.

## Operation
- Fetch has a two-state FSM.
  - OPCODE: latch imem_data_i[31:16] and the PC.
  - If the opcode is ldi.l (0x01) or jmpa (0x1a), go to OPERAND. Otherwise emit valid and set PC += 2.
  - OPERAND: address is PC+2. Latch imem_data_i[31:0] as the operand, emit valid, set PC += 6, return to OPCODE.
- Decode registers these fields: op class, rA, rB, operand, PC, valid.
- Form 1 (bit15=0): op = [15:8], rA = [7:4], rB = [3:0].
  - 0x01 ldi.l: rA ← imm32.
  - 0x02 mov: rA ← rB.
  - 0x05 add.l: rA ← rA + rB.
  - 0x0b st.l: mem[rA] ← rB.
  - 0x0e cmp: flags ← compare(rA, rB).
  - 0x1a jmpa: PC ← imm32.
  - 0x26 and, 0x29 sub.l (rA − rB), 0x2b or, 0x2e xor.
  - All other opcodes, including 0x0f, execute as nop.
- Form 2 (bits 15:14 = 10): reg = [11:8], imm8 = [7:0] zero-extended.
  - [13:12] = 00: inc, reg ← reg + imm8.
  - [13:12] = 01: dec, reg ← reg − imm8.
  - Other values: nop.
- Form 3 (bits 15:14 = 11): cond = [13:10], off = [9:0].
  - Conditions 0–5 are beq, bne, blt, bgt, bltu, bgtu.
  - Conditions 6–15 are nop.
  - Target = branch PC + 2 + sign_extend(off)·2.
- riA_o/riB_o come from the decode register. For form 2, riA_o = [11:8].
- Execute updates a flags register on cmp only: eq, signed lt, signed gt, unsigned lt, unsigned gt. Flags reset to 0.
- Arithmetic is 32-bit modulo 2^32. There is no carry or overflow output.
- Register writes: mov, ldi.l, ALU ops, inc and dec set register_write_enable_o and write index rA.
- st.l sets memory_write_enable_o, with address = regA_i and result_o = regB_i. register_write_enable_o stays 0.
- Taken branch or jmpa:
  - Fetch loads the target.
  - The fetch and decode registers are squashed (valid = 0).
  - The fetch FSM returns to OPCODE.
- Invalid slots and nops drive both write enables to 0. Data outputs hold their last values.
- There is no interlock and no forwarding. Software separates a producer from a consumer by at least 3 instructions (block latency plus external write stage).
- Reset clears:
  - all valids, flags and output registers (to 0);
  - the FSM (to OPCODE);
  - the PC (to RESET_PC).

## Timing
- A short instruction presented in cycle n is visible on the execute outputs in cycle n+3. A 6-byte instruction with its opcode in cycle n is visible in cycle n+4.
- Branches resolve combinationally in execute, using the flags register.
  - imem_address_o = target in the cycle after the branch sits in execute.
  - Exactly the two younger in-flight instructions are squashed.
- A cmp immediately followed by a branch works: flags are registered at the cmp's execute edge.
- On an edge with stall_i = 1:
  - the PC, FSM, fetch register and decode register hold;
  - execute loads a bubble (both enables 0, no branch).
- No instruction is lost or duplicated across a stall.
- A branch in execute is not taken while stall_i = 1. It is re-evaluated once the stall is released.
- rst_i has priority over stall_i and branches.

## Test plan
- Reset: hold rst_i 2 cycles, then release.
  - During reset: imem_address_o = 0x1000 and all enables are 0.
  - After release: addresses advance 0x1000, 0x1002, … per cycle.
- ldi.l: memory at 0x1000 holds 0x0110_1234_5678.
  - register_write_enable_o = 1, index 1, result_o = 0x12345678, in cycle 4.
  - The next fetch address is 0x1006.
- add.l $r2,$r3 (0x0523) with regA_i = 5, regB_i = 7: result_o = 12, index 2. sub.l with the same values gives 0xFFFFFFFE.
- cmp $r1,$r2 with equal values, then beq off = +4:
  - imem_address_o jumps to branch PC + 10;
  - the two following instructions produce no write enables.
- st.l (0x0B12) with regA_i = 0x2000, regB_i = 0xCAFE:
  - memory_write_enable_o = 1, address 0x2000, result_o = 0xCAFE;
  - register_write_enable_o = 0.
- stall_i held 3 cycles mid-stream: imem_address_o stays constant and enables are 0. After release, the instruction sequence is complete with no duplicate writes.
